// File: rtl/bus_slave_pkg.sv
// Shared widths, idle bus value and address-phase state type for the bus data slave.
package bus_slave_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 8;
  localparam logic [DATA_W-1:0] BUS_IDLE_DATA = 16'hFFFF;

  typedef enum logic {
    IDLE = 1'b0,
    ADDR = 1'b1
  } addrState_e;

endpackage

// File: rtl/bus_regfile.sv
// 16x16 storage for the bus data slave with synchronous reset to RST_DATA.
// Even-parity bit per word when BUS_SLAVE_PARITY_EN is defined.
module bus_regfile
  import bus_slave_pkg::*;
#(
  parameter logic [DATA_W-1:0] RST_DATA = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              par_inj_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rpar_ok_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RST_DATA;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

`ifdef BUS_SLAVE_PARITY_EN
  logic [DEPTH-1:0] par_q;

  // Stored bit makes data+parity even; par_inj flips it to plant a fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= {DEPTH{^RST_DATA}};
    end else if (we_i) begin
      par_q[waddr_i] <= (^wdata_i) ^ par_inj_i;
    end
  end

  assign rpar_ok_o = ((^rdata_o) == par_q[raddr_i]);
`else
  logic unusedParInj;
  assign unusedParInj = par_inj_i;
  assign rpar_ok_o    = 1'b1;
`endif

endmodule

// File: rtl/bus_data_slave.sv
// Multiplexed-bus data slave: address decode, address-phase FSM, sticky errors, counters.
// Optional per-word parity is enabled by defining BUS_SLAVE_PARITY_EN.
module bus_data_slave
  import bus_slave_pkg::*;
#(
  parameter logic [DATA_W-ADDR_W-1:0] BASE_ADDR = 12'h000,
  parameter logic [DATA_W-1:0]        RST_DATA  = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ad_in,
  input  logic              la,
  input  logic              oe,
  input  logic              wd,
  input  logic              clr_err,
  input  logic              par_inj,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  output logic              addr_err,
  output logic              proto_err,
  output logic              par_err,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt
);

  addrState_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hit_q, hit_d;
  logic [DATA_W-1:0] ad_out_q, ad_out_d;
  logic              ad_oe_q, ad_oe_d;
  logic              addr_err_q, addr_err_d;
  logic              proto_err_q, proto_err_d;
  logic              par_err_q, par_err_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              memWe;
  logic [DATA_W-1:0] memRdata;
  logic              memParOk;

  bus_regfile #(.RST_DATA(RST_DATA)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we_i      (memWe),
    .waddr_i   (addr_q),
    .wdata_i   (ad_in),
    .par_inj_i (par_inj),
    .raddr_i   (addr_q),
    .rdata_o   (memRdata),
    .rpar_ok_o (memParOk)
  );

  // Flags clear first so that an error raised on the same edge wins over clr_err.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    hit_d       = hit_q;
    ad_out_d    = ad_out_q;
    ad_oe_d     = 1'b0;
    addr_err_d  = clr_err ? 1'b0 : addr_err_q;
    proto_err_d = clr_err ? 1'b0 : proto_err_q;
    par_err_d   = clr_err ? 1'b0 : par_err_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    memWe       = 1'b0;

    if (la) begin
      addr_d  = ad_in[ADDR_W-1:0];
      hit_d   = (ad_in[DATA_W-1:ADDR_W] == BASE_ADDR);
      state_d = ADDR;
      if (oe || wd) proto_err_d = 1'b1;
    end else if (oe || wd) begin
      if (state_q == IDLE) begin
        proto_err_d = 1'b1;
      end else begin
        state_d = IDLE;
        if (!hit_q) addr_err_d = 1'b1;
        if (wd) begin
          if (oe) proto_err_d = 1'b1;
          if (hit_q) begin
            memWe    = 1'b1;
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end else begin
          ad_oe_d = 1'b1;
          if (hit_q) begin
            ad_out_d = memRdata;
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (!memParOk) par_err_d = 1'b1;
          end else begin
            ad_out_d = BUS_IDLE_DATA;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      hit_q       <= 1'b0;
      ad_out_q    <= '0;
      ad_oe_q     <= 1'b0;
      addr_err_q  <= 1'b0;
      proto_err_q <= 1'b0;
      par_err_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      hit_q       <= hit_d;
      ad_out_q    <= ad_out_d;
      ad_oe_q     <= ad_oe_d;
      addr_err_q  <= addr_err_d;
      proto_err_q <= proto_err_d;
      par_err_q   <= par_err_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
    end
  end

  assign ad_out    = ad_out_q;
  assign ad_oe     = ad_oe_q;
  assign addr_err  = addr_err_q;
  assign proto_err = proto_err_q;
  assign par_err   = par_err_q;
  assign wr_cnt    = wr_cnt_q;
  assign rd_cnt    = rd_cnt_q;

endmodule

// File: doc/bus_data_slave.md
BUS_DATA_SLAVE -- requirements
Module: bus_data_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 12'h000, upper 12 address bits decoded as this slave's window.
REQ-002 SHALL have parameter RST_DATA, default 16'h0000, reset value of every storage word.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port ad_in  in  16  multiplexed address/data bus from the master.
REQ-006 SHALL have port la  in  1  address-latch strobe from the upstream control FSM.
REQ-007 SHALL have port oe  in  1  read data-phase strobe from the upstream control FSM.
REQ-008 SHALL have port wd  in  1  write data-phase strobe from the upstream control FSM.
REQ-009 SHALL have port clr_err  in  1  clears sticky error flags.
REQ-010 SHALL have port par_inj  in  1  parity-fault injection on write (PARITY_EN builds only).
REQ-011 SHALL have port ad_out  out  16  read data.
REQ-012 SHALL have port ad_oe  out  1  bus-drive enable; high while ad_out is valid.
REQ-013 SHALL have port addr_err  out  1  sticky: access outside the window.
REQ-014 SHALL have port proto_err  out  1  sticky: strobe-sequence violation.
REQ-015 SHALL have port par_err  out  1  sticky: read parity mismatch.
REQ-016 SHALL have port wr_cnt  out  8  count of completed in-window writes.
REQ-017 SHALL have port rd_cnt  out  8  count of completed in-window reads.

Function
REQ-018 SHALL hold 16 words x 16 bits, indexed by latched address bits [3:0].
REQ-019 On a clk edge with la=1, SHALL capture ad_in[3:0] as addr_q, set hit_q = (ad_in[15:4]==BASE_ADDR) and set addr_vld=1.
REQ-020 Address-phase FSM states: IDLE (addr_vld=0) -> ADDR (la seen) -> back to IDLE after exactly one oe or wd edge; a new la in ADDR re-captures the address and stays in ADDR.
REQ-021 On an oe edge in ADDR with hit_q=1, SHALL register mem[addr_q] into ad_out and assert ad_oe for exactly the following cycle, then increment rd_cnt.
REQ-022 On an oe edge in ADDR with hit_q=0, SHALL drive ad_out=16'hFFFF with ad_oe for one cycle, set addr_err, and leave rd_cnt unchanged.
REQ-023 On a wd edge in ADDR with hit_q=1, SHALL write ad_in into mem[addr_q] on that edge and increment wr_cnt; with hit_q=0, SHALL drop the write and set addr_err.
REQ-024 A read issued the cycle after a write to the same address SHALL return the new data.
REQ-025 oe or wd while in IDLE SHALL be ignored (no storage change, ad_oe stays 0) and SHALL set proto_err.
REQ-026 oe and wd together SHALL perform the write only, suppress the read, and set proto_err.
REQ-027 la together with oe or wd SHALL ignore the strobe, capture the new address, and set proto_err.
REQ-028 wr_cnt and rd_cnt SHALL wrap 8'hFF -> 8'h00.
REQ-029 clr_err=1 SHALL clear all sticky flags on that edge; an error event on the same edge SHALL win (flag stays 1).
REQ-030 ad_oe SHALL be 0 except in the single cycle following a read edge; ad_out SHALL hold its last value while ad_oe=0.

Reset
REQ-031 rst SHALL force IDLE, addr_vld=0, ad_oe=0, ad_out=16'h0000, all error flags 0, both counters 0, all words = RST_DATA.
REQ-032 rst asserted mid-access SHALL abort it: no write, no ad_oe in the next cycle.

Configuration
REQ-033 Macro BUS_SLAVE_PARITY_EN defined: one even-parity bit SHALL be stored per word, inverted when par_inj=1 at write; a read with mismatch SHALL set par_err and still return the data.
REQ-034 Macro undefined: no parity storage SHALL exist, par_inj SHALL be ignored and par_err SHALL be tied 0.

Structure
REQ-035 Package bus_slave_pkg SHALL hold ADDR_W=4, DATA_W=16, DEPTH=16, BUS_IDLE_DATA=16'hFFFF and the address-phase state enum.
REQ-036 Storage plus optional parity SHALL be the sub-module bus_regfile; decoding, FSM, flags and counters SHALL stay in bus_data_slave.

Verification
REQ-037 la with ad_in=16'h0005, then wd with ad_in=16'hBEEF; la 16'h0005, oe -> next cycle ad_out=16'hBEEF, ad_oe=1, wr_cnt=1, rd_cnt=1.
REQ-038 la with ad_in=16'h0123 (BASE_ADDR=0), oe -> ad_out=16'hFFFF, ad_oe=1, addr_err=1, rd_cnt=0; clr_err -> addr_err=0.
REQ-039 oe with no preceding la after reset -> ad_oe=0, proto_err=1; la then oe=wd=1 -> write done, no ad_oe, proto_err=1.
REQ-040 256 in-window writes -> wr_cnt=8'h00; 255 -> 8'hFF.
REQ-041 rst during the oe cycle -> next cycle ad_oe=0, ad_out=16'h0000, all words read back RST_DATA.
REQ-042 BUS_SLAVE_PARITY_EN defined: write 16'h00FF with par_inj=1, read same address -> ad_out=16'h00FF, par_err=1; without the macro -> par_err=0.
